// File: rtl/data_sram_resp.sv
// Responder end of the core's data_sram port: byte-enabled writes into a word array,
// registered reads returned after READ_LAT cycles with a stall request while waiting.
module data_sram_resp #(
  parameter int ADDR_WIDTH = 10,
  parameter int READ_LAT   = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_for_mem,
  output logic        wen_err
);

  typedef enum logic [1:0] {IDLE, WAIT, LAST} state_t;

  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'((READ_LAT >= 3) ? (READ_LAT - 3) : 0);

  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] lidx;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  legal;
  logic                  is_read;
  logic                  is_write;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  err_next;
  logic                  unused_addr_bits;

  // Address bits above the word index alias onto the same entry.
  assign idx              = data_sram_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^data_sram_addr[31:ADDR_WIDTH+2];

  always_comb begin
    legal = 1'b0;
    case ({data_sram_wen, data_sram_addr[1:0]})
      6'b0001_00, 6'b0010_01, 6'b0100_10, 6'b1000_11,
      6'b0011_00, 6'b1100_10, 6'b1111_00: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
  end

  assign is_read  = (state == IDLE) && data_sram_en && (data_sram_wen == 4'b0000);
  assign is_write = (state == IDLE) && data_sram_en && (data_sram_wen != 4'b0000);
  assign wr_fire  = resetn && is_write && legal;
  assign err_next = is_write && !legal;
  assign rd_fire  = resetn && ((is_read && (READ_LAT == 1)) || (state == LAST));
  assign rd_idx   = (state == LAST) ? lidx : idx;

  assign stallreq_for_mem = resetn && ((is_read && (READ_LAT > 1)) || (state == WAIT));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      lidx    <= '0;
      wen_err <= 1'b0;
    end else begin
      wen_err <= err_next;
      case (state)
        IDLE: begin
          if (is_read && (READ_LAT > 1)) begin
            lidx <= idx;
            if (READ_LAT == 2) begin
              state <= LAST;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= LAST;
          else             cnt   <= cnt - 4'd1;
        end
        LAST:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // One byte-wide RAM per lane so each lane infers its own block RAM with a registered read.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (wr_fire && data_sram_wen[gi]) mem[idx] <= data_sram_wdata[gi*8 +: 8];
    end

    always_ff @(posedge clk) begin
      if (!resetn)      q <= 8'd0;
      else if (rd_fire) q <= mem[rd_idx];
    end
  end

  assign data_sram_rdata = {g_lane[3].q, g_lane[2].q, g_lane[1].q, g_lane[0].q};

endmodule
